alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_iter.sv | 133 +++++++++++++
 tb/tb_alu_iter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and controller state encoding shared by the iterative ALU.
`default_nettype none
package alu_pkg;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ADC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per clock.
`default_nettype none
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_active;

    // Bit 0 is folded into the load so the product is final WIDTH-1 clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
            r_mplier <= {1'b0, i_b[WIDTH-1:1]};
            r_cnt    <= CW'(WIDTH-1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                r_cnt    <= r_cnt - CW'(1);
            end
        end
    end

    assign o_done    = r_active && (r_cnt == '0);
    assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU with single-cycle logic/add/shift ops and an iterative multiply.
`default_nettype none
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             z,
    output logic             c,
    output logic             busy
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_o;
    logic               r_c;
    logic               r_cf;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_o;
    logic               w_alu_c;

    assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_mul_start = w_accept && (op == OP_MUL);

    // Single adder shared by ADD/SUB/ADC; SUB is ina + ~inb + 1.
    assign w_add_b = (op == OP_SUB) ? ~inb : inb;
    assign w_cin   = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? r_cf : 1'b0);
    assign w_sum   = {1'b0, ina} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_alu_o = '0;
        w_alu_c = 1'b0;
        case (op)
            OP_NAND: w_alu_o = ~(ina & inb);
            OP_ADD, OP_SUB, OP_ADC: {w_alu_c, w_alu_o} = w_sum;
            OP_SHL: begin
                w_alu_o = {ina[WIDTH-2:0], 1'b0};
                w_alu_c = ina[WIDTH-1];
            end
            OP_SHR: begin
                w_alu_o = {1'b0, ina[WIDTH-1:1]};
                w_alu_c = ina[0];
            end
            default: begin
                w_alu_o = '0;
                w_alu_c = 1'b0;
            end
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (ina),
        .i_b       (inb),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (op == OP_MUL) ? ST_MUL : ST_HOLD;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = (op == OP_MUL) ? ST_MUL : ST_HOLD;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // cf tracks the carry of whichever result was registered last, multiply included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o  <= '0;
            r_c  <= 1'b0;
            r_cf <= 1'b0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_o  <= w_alu_o;
            r_c  <= w_alu_c;
            r_cf <= w_alu_c;
        end else if ((r_state == ST_MUL) && w_mul_done) begin
            r_o  <= w_product[WIDTH-1:0];
            r_c  <= |w_product[2*WIDTH-1:WIDTH];
            r_cf <= |w_product[2*WIDTH-1:WIDTH];
        end
    end

    assign o         = r_o;
    assign z         = (r_o == '0);
    assign c         = r_c;
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed and randomized checks of alu_iter against a transaction-level model.
`default_nettype none
`timescale 1ns/1ps
module tb_alu_iter;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] ina = '0;
    logic [W-1:0] inb = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] o;
    logic         z;
    logic         c;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .ina       (ina),
        .inb       (inb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .z         (z),
        .c         (c),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", nm, $time, got, exp);
        end
    endtask

    // Result of one operation from plain integer arithmetic.
    function automatic void ref_calc(input logic [2:0] f_op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input bit cin,
                                     output logic [W-1:0] r, output bit co);
        longint unsigned mask, s, ua, ub;
        mask = (64'd1 << W) - 64'd1;
        ua = 64'(a);
        ub = 64'(b);
        s  = 0;
        co = 1'b0;
        case (f_op)
            OP_NAND: s = ~(ua & ub) & mask;
            OP_ADD:  begin s = ua + ub;                    co = ((s >> W) & 1) != 0; end
            OP_SUB:  begin s = ua + ((~ub) & mask) + 1;    co = ((s >> W) & 1) != 0; end
            OP_ADC:  begin s = ua + ub + 64'(cin);         co = ((s >> W) & 1) != 0; end
            OP_SHL:  begin s = (ua << 1) & mask;           co = ((ua >> (W-1)) & 1) != 0; end
            OP_SHR:  begin s = ua >> 1;                    co = (ua & 1) != 0; end
            OP_MUL:  begin s = ua * ub;                    co = (s >> W) != 0; end
            default: s = 0;
        endcase
        r = W'(s & mask);
    endfunction

    // Transaction model: a held result, or a multiply with m_left clocks remaining.
    bit           m_valid;
    logic [W-1:0] m_o;
    bit           m_c;
    bit           m_cf;
    int           m_left;
    logic [W-1:0] m_pa;
    logic [W-1:0] m_pb;

    always @(posedge clk or negedge rst_n) begin
        bit           rdy;
        logic [W-1:0] r;
        bit           co;
        if (!rst_n) begin
            m_valid = 0; m_o = '0; m_c = 0; m_cf = 0; m_left = 0;
        end else begin
            rdy = (m_left == 0) && (!m_valid || out_ready);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    ref_calc(OP_MUL, m_pa, m_pb, 1'b0, r, co);
                    m_o = r; m_c = co; m_cf = co; m_valid = 1;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (in_valid && rdy) begin
                    if (op == OP_MUL) begin
                        m_left = W; m_pa = ina; m_pb = inb;
                    end else begin
                        ref_calc(op, ina, inb, m_cf, r, co);
                        m_o = r; m_c = co; m_cf = co; m_valid = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_out_valid", 64'(out_valid), 64'(m_valid));
        chk("m_busy", 64'(busy), 64'(m_left > 0));
        chk("m_in_ready", 64'(in_ready), 64'((m_left == 0) && (!m_valid || out_ready)));
        chk("m_o", 64'(o), 64'(m_o));
        chk("m_c", 64'(c), 64'(m_c));
        chk("m_z", 64'(z), 64'(m_o == '0));
    end

    // Entry and exit at #1 after a rising edge.
    task automatic issue(input logic [2:0] f_op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        op = f_op; ina = a; inb = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [W-1:0] eo, input bit ez, input bit ec);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_o"}, 64'(o), 64'(eo));
        chk({nm, "_z"}, 64'(z), 64'(ez));
        chk({nm, "_c"}, 64'(c), 64'(ec));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        bit           co;
        int           n;

        ref_calc(OP_SUB, 16'h0003, 16'h0005, 1'b0, r, co);
        chk("ref_sub_o", 64'(r), 64'hFFFE);
        chk("ref_sub_c", 64'(co), 64'd0);
        ref_calc(OP_MUL, 16'h0100, 16'h0100, 1'b0, r, co);
        chk("ref_mul_c", 64'(co), 64'd1);
        ref_calc(OP_ADC, 16'h0000, 16'h0000, 1'b1, r, co);
        chk("ref_adc_o", 64'(r), 64'h0001);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_o", 64'(o), 64'd0);
        chk("rst_z", 64'(z), 64'd1);
        @(posedge clk); #1;

        issue(OP_ADD, 16'hFFFF, 16'h0001);
        wait_result("add_ovf", 16'h0000, 1'b1, 1'b1);
        issue(OP_ADC, 16'h0000, 16'h0000);
        wait_result("adc_cf", 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        issue(OP_MUL, 16'h0100, 16'h0100);
        n = 0;
        while (busy && n < 100) begin
            chk("mul_in_ready", 64'(in_ready), 64'd0);
            n++;
            @(posedge clk); #1;
        end
        chk("mul_busy_cycles", 64'(n), 64'(W));
        wait_result("mul_big", 16'h0000, 1'b1, 1'b1);
        issue(OP_MUL, 16'h00FF, 16'h0002);
        wait_result("mul_small", 16'h01FE, 1'b0, 1'b0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        issue(OP_SUB, 16'h0003, 16'h0005);
        repeat (5) begin
            wait_result("sub_hold", 16'hFFFE, 1'b0, 1'b0);
            chk("sub_hold_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("sub_released", 64'(out_valid), 64'd0);

        issue(OP_MUL, 16'h1234, 16'h5678);
        repeat (6) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_z", 64'(z), 64'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        issue(OP_NAND, 16'hFFFF, 16'hFFFF);
        wait_result("nand_ones", 16'h0000, 1'b1, 1'b0);

        issue(OP_SHL, 16'h8001, 16'h0000);
        wait_result("shl", 16'h0002, 1'b0, 1'b1);
        issue(OP_SHR, 16'h8001, 16'h0000);
        wait_result("shr", 16'h4000, 1'b0, 1'b1);
        @(posedge clk); #1;

        repeat (800) begin
            in_valid  = ($urandom % 3) != 0;
            op        = 3'($urandom);
            case ($urandom % 4)
                0: ina = '1;
                1: ina = '0;
                default: ina = W'($urandom);
            endcase
            case ($urandom % 4)
                0: inb = '1;
                1: inb = 16'h0001;
                default: inb = W'($urandom);
            endcase
            out_ready = ($urandom % 4) != 0;
            if (($urandom % 150) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
